// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler:
// frame FSM encodings, frame geometry and the baud increment helper.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CNT_W      = $clog2(DATA_BITS);

  // Phase increment so that the accumulator carries at the baud rate.
  function automatic int unsigned baud_inc(input int unsigned clk_hz,
                                           input int unsigned baud_rate,
                                           input int unsigned acc_w);
    return 32'((64'(baud_rate) << acc_w) / 64'(clk_hz));
  endfunction

endpackage

// File: rtl/baud_tick_acc.sv
// Clearable fractional phase accumulator producing one tick per serial bit period.
// The tick is the carry of the sum about to be stored, so it lines up with that edge.
module baud_tick_acc
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned clkFrequency          = 50000000,
  parameter int unsigned baud                  = 9600,
  parameter int unsigned baudGeneratorAccWidth = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned W   = baudGeneratorAccWidth;
  localparam int unsigned INC = baud_inc(clkFrequency, baud, baudGeneratorAccWidth);

  logic [W:0] acc;
  logic [W:0] sum;

  assign sum  = {1'b0, acc[W-1:0]} + (W+1)'(INC);
  assign tick = run & ~clear & sum[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (run) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one 8N1 serial transmitter between two byte requesters.
// The bit timer restarts at every grant so each frame is bit-aligned.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned clkFrequency          = 50000000,
  parameter int unsigned baud                  = 9600,
  parameter int unsigned baudGeneratorAccWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack1,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id
);

  tx_state_e            state, state_d;
  logic [DATA_BITS-1:0] shifter, shifter_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 tx_d, busy_d, ack0_d, ack1_d, grant_id_d;
  logic                 sel;
  logic                 tick;
  logic                 acc_clear, acc_run;

  // Accumulator held at zero while idle, so counting starts from the grant edge.
  assign acc_clear = (state == S_IDLE);
  assign acc_run   = (state != S_IDLE);

  baud_tick_acc #(
    .clkFrequency         (clkFrequency),
    .baud                 (baud),
    .baudGeneratorAccWidth(baudGeneratorAccWidth)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(acc_clear),
    .run  (acc_run),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shifter  <= '0;
      cnt      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      grant_id <= 1'b1;
    end else begin
      state    <= state_d;
      shifter  <= shifter_d;
      cnt      <= cnt_d;
      tx       <= tx_d;
      busy     <= busy_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      grant_id <= grant_id_d;
    end
  end

  always_comb begin
    state_d    = state;
    shifter_d  = shifter;
    cnt_d      = cnt;
    tx_d       = tx;
    busy_d     = busy;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    grant_id_d = grant_id;
    sel        = 1'b0;

    case (state)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (req0 || req1) begin
          // On a tie the requester that did not own the last frame wins.
          sel        = (req0 && req1) ? ~grant_id : req1;
          shifter_d  = sel ? data1 : data0;
          ack0_d     = ~sel;
          ack1_d     = sel;
          grant_id_d = sel;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d      = shifter[0];
          shifter_d = shifter >> 1;
          cnt_d     = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt == CNT_W'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d      = shifter[0];
            shifter_d = shifter >> 1;
            cnt_d     = cnt + CNT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler at 16 clocks per bit (clkFrequency=16, baud=1, W=4).
module tb_uart_tx_scheduler;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned BAUD   = 1;
  localparam int unsigned ACC_W  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, tx, busy, grant_id;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler #(
    .clkFrequency(CLK_HZ),
    .baud(BAUD),
    .baudGeneratorAccWidth(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for the next negedge at which an ack is visible.
  task automatic wait_ack(input string name, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(ack0 || ack1) && waited < 400);
    checks++;
    if (!(ack0 || ack1)) begin
      errors++;
      $display("FAIL %s ack_timeout got none after %0d cycles exp an ack", name, waited);
    end
  endtask

  // Called at the negedge where the ack is seen (k=0); samples bit centres up to k=160.
  task automatic rx_frame(output logic [7:0] d, output logic sb, output logic pb,
                          output int busy_n, output int acks);
    d = '0; sb = 1'b1; pb = 1'b0; busy_n = 0; acks = 0;
    for (int k = 0; k <= 160; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_n++;
      if (k > 0 && (ack0 || ack1)) acks++;
      if (k == 8) sb = tx;
      if (k >= 24 && k <= 136 && ((k - 24) % 16) == 0) d[(k - 24) / 16] = tx;
      if (k == 152) pb = tx;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL rst_ack got %b%b exp 00", ack0, ack1); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rst_grant_id got %b exp 1", grant_id); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({tx, busy} !== 2'b10) begin errors++; $display("FAIL idle_line got tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_single();
    int w, bn, na; logic [7:0] d; logic sb, pb;
    req0 = 1'b1; data0 = 8'hA5;
    wait_ack("single", w);
    checks++; if (w !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", w); end
    checks++; if ({ack0, ack1, grant_id} !== 3'b100) begin errors++; $display("FAIL single_grant got ack0=%b ack1=%b gid=%b exp 1 0 0", ack0, ack1, grant_id); end
    checks++; if ({tx, busy} !== 2'b01) begin errors++; $display("FAIL single_start got tx=%b busy=%b exp tx=0 busy=1", tx, busy); end
    req0 = 1'b0;
    rx_frame(d, sb, pb, bn, na);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", d); end
    checks++; if ({sb, pb} !== 2'b01) begin errors++; $display("FAIL single_framing got start=%b stop=%b exp 0 1", sb, pb); end
    checks++; if (bn !== 160) begin errors++; $display("FAIL single_busy_len got %0d exp 160", bn); end
    checks++; if (na !== 0) begin errors++; $display("FAIL single_ack_width got %0d extra acks exp 0", na); end
    checks++; if ({tx, busy} !== 2'b10) begin errors++; $display("FAIL single_end got tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_tie();
    int w, bn, na; logic [7:0] d; logic sb, pb;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
    wait_ack("tie1", w);
    checks++; if ({ack0, ack1, grant_id} !== 3'b100) begin errors++; $display("FAIL tie1_grant got ack0=%b ack1=%b gid=%b exp 1 0 0", ack0, ack1, grant_id); end
    req0 = 1'b0;
    rx_frame(d, sb, pb, bn, na);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL tie1_data got %h exp 11", d); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tie_gap got tx=%b exp 1", tx); end
    wait_ack("tie2", w);
    checks++; if ({ack0, ack1, grant_id, w} !== {3'b011, 32'd1}) begin errors++; $display("FAIL tie2_grant got ack0=%b ack1=%b gid=%b wait=%0d exp 0 1 1 1", ack0, ack1, grant_id, w); end
    req1 = 1'b0;
    rx_frame(d, sb, pb, bn, na);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL tie2_data got %h exp 22", d); end
  endtask

  task automatic test_round_robin();
    int w, bn, na; logic [7:0] d; logic sb, pb;
    logic [7:0] exp_d [3] = '{8'h33, 8'h44, 8'h33};
    logic       exp_g [3] = '{1'b1, 1'b0, 1'b1};
    req1 = 1'b1; data1 = 8'h33;
    for (int i = 0; i < 3; i++) begin
      wait_ack("rr", w);
      checks++; if (grant_id !== exp_g[i] || ack1 !== exp_g[i] || ack0 !== ~exp_g[i]) begin
        errors++; $display("FAIL rr_grant%0d got gid=%b ack0=%b ack1=%b exp gid=%b", i, grant_id, ack0, ack1, exp_g[i]);
      end
      if (i == 0) begin req0 = 1'b1; data0 = 8'h44; end
      if (i == 1) req0 = 1'b0;
      if (i == 2) req1 = 1'b0;
      rx_frame(d, sb, pb, bn, na);
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL rr_data%0d got %h exp %h", i, d, exp_d[i]); end
    end
  endtask

  task automatic test_busy_wait();
    int w, bn, na, early; logic [7:0] d; logic sb, pb;
    req0 = 1'b1; data0 = 8'h96;
    wait_ack("bw0", w);
    req0 = 1'b0;
    early = 0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 40) begin req1 = 1'b1; data1 = 8'h69; end
      if (ack1) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL bw_early_ack got %0d exp 0", early); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bw_busy_fall got %b exp 0", busy); end
    wait_ack("bw1", w);
    checks++; if ({ack1, w} !== {1'b1, 32'd1}) begin errors++; $display("FAIL bw_ack1 got ack1=%b wait=%0d exp 1 1", ack1, w); end
    req1 = 1'b0;
    rx_frame(d, sb, pb, bn, na);
    checks++; if (d !== 8'h69) begin errors++; $display("FAIL bw_data got %h exp 69", d); end
  endtask

  task automatic test_reset_mid();
    int w, bn, na; logic [7:0] d; logic sb, pb;
    req0 = 1'b1; data0 = 8'hC3;
    wait_ack("rm0", w);
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({tx, busy, ack0, grant_id} !== 4'b1001) begin errors++; $display("FAIL rm_async got tx=%b busy=%b ack0=%b gid=%b exp 1 0 0 1", tx, busy, ack0, grant_id); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack("rm1", w);
    checks++; if ({ack0, w} !== {1'b1, 32'd1}) begin errors++; $display("FAIL rm_reack got ack0=%b wait=%0d exp 1 1", ack0, w); end
    req0 = 1'b0;
    rx_frame(d, sb, pb, bn, na);
    checks++; if (d !== 8'hC3 || bn !== 160) begin errors++; $display("FAIL rm_frame got %h len %0d exp c3 len 160", d, bn); end
  endtask

  task automatic test_data_change();
    int w, bn, na; logic [7:0] d; logic sb, pb;
    req0 = 1'b1; data0 = 8'h3C;
    wait_ack("dc", w);
    data0 = 8'hFF; req0 = 1'b0;
    rx_frame(d, sb, pb, bn, na);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL dc_data got %h exp 3c", d); end
    checks++; if ({sb, pb} !== 2'b01) begin errors++; $display("FAIL dc_framing got start=%b stop=%b exp 0 1", sb, pb); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_busy_wait();
    test_reset_mid();
    test_data_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
